// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the I2S capture path
package i2s_pkg;
  typedef enum logic {IDLE, SEND} packer_state_t;
  localparam int BYTE_W = 8;
  function automatic bit size_ok(input int w);
    return w > 0 && w % BYTE_W == 0;
  endfunction
endpackage

// File: rtl/i2s_sample_packer_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);
  always_ff @(posedge clk or posedge rst)
    if (rst) value <= '0;
    else if (inc && !(&value)) value <= value + W'(1);
endmodule

// File: rtl/i2s_sample_packer.sv
// i2s_sample_packer: keeps the top REDUCE_FACTOR bytes of each sample and writes them MSB first
module i2s_sample_packer
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE     = 24,
  parameter int FIFO_WIDTH    = 8,
  parameter int REDUCE_FACTOR = 2,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [DATA_SIZE-1:0]  sample_data,
  output logic                  fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam int KW = REDUCE_FACTOR * BYTE_W;
  localparam int IW = $clog2(REDUCE_FACTOR + 1);
  localparam logic [IW-1:0] LAST = IW'(REDUCE_FACTOR - 1);
  generate
    if (!size_ok(DATA_SIZE) || FIFO_WIDTH != BYTE_W || REDUCE_FACTOR < 1 || REDUCE_FACTOR > DATA_SIZE / BYTE_W) begin : g_bad
      $error("i2s_sample_packer: illegal DATA_SIZE/FIFO_WIDTH/REDUCE_FACTOR");
    end
  endgenerate
  packer_state_t r_state;
  logic [KW-1:0] r_shift;
  logic [IW-1:0] r_idx;
  logic          w_last, w_accept, w_drop;
  assign fifo_wr_en   = (r_state == SEND) && !fifo_full;
  assign fifo_wr_data = r_shift[KW-1 -: BYTE_W];
  assign busy         = (r_state == SEND);
  assign w_last       = fifo_wr_en && (r_idx == LAST);
  assign w_accept     = sample_valid && enable && ((r_state == IDLE) || w_last);
  assign w_drop       = sample_valid && enable && (r_state == SEND) && !w_last;
  // The final byte is not shifted out so the output keeps its last value while idle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_state <= SEND;
      r_shift <= sample_data[DATA_SIZE-1 -: KW];
      r_idx   <= '0;
    end else if (fifo_wr_en) begin
      if (w_last) r_state <= IDLE;
      else begin
        r_shift <= r_shift << BYTE_W;
        r_idx   <= r_idx + IW'(1);
      end
    end
  sat_counter #(.W(DROP_CNT_W)) u_drop (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_drop),
    .value(drop_count)
  );
endmodule

// File: tb/tb_i2s_sample_packer.sv
// tb_i2s_sample_packer: four packer variants driven in parallel against a per-variant sample/byte model
module tb_i2s_sample_packer;
  logic        clk = 0, rst = 1, en = 1, sv = 0, full = 0;
  logic [23:0] sd = '0;
  logic [3:0]  we, bz;
  logic [7:0]  wd [4];
  logic [15:0] dc0, dc2, dc3;
  logic [1:0]  dc1;
  int checks = 0, failures = 0, cyc = 0;
  int rf [4]   = '{2, 2, 3, 1};
  int dmax [4] = '{65535, 3, 65535, 65535};
  logic [23:0] ms [4];
  bit  act [4];
  int  sent [4], drop [4];
  logic [7:0] lg [4][16];
  int  lcy [4][16];
  int  lc [4];

  always #5 clk = ~clk;

  i2s_sample_packer u0 (.clk(clk), .rst(rst), .enable(en), .sample_valid(sv), .sample_data(sd),
    .fifo_wr_en(we[0]), .fifo_wr_data(wd[0]), .fifo_full(full), .busy(bz[0]), .drop_count(dc0));
  i2s_sample_packer #(.DROP_CNT_W(2)) u1 (.clk(clk), .rst(rst), .enable(en), .sample_valid(sv), .sample_data(sd),
    .fifo_wr_en(we[1]), .fifo_wr_data(wd[1]), .fifo_full(full), .busy(bz[1]), .drop_count(dc1));
  i2s_sample_packer #(.REDUCE_FACTOR(3)) u2 (.clk(clk), .rst(rst), .enable(en), .sample_valid(sv), .sample_data(sd),
    .fifo_wr_en(we[2]), .fifo_wr_data(wd[2]), .fifo_full(full), .busy(bz[2]), .drop_count(dc2));
  i2s_sample_packer #(.REDUCE_FACTOR(1)) u3 (.clk(clk), .rst(rst), .enable(en), .sample_valid(sv), .sample_data(sd),
    .fifo_wr_en(we[3]), .fifo_wr_data(wd[3]), .fifo_full(full), .busy(bz[3]), .drop_count(dc3));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  // Model: a pending sample plus a count of bytes already sent; bytes come from the top of the sample.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] dv;
      bit ewe, lst, acc, drp;
      dv = k == 0 ? dc0 : k == 1 ? {14'b0, dc1} : k == 2 ? dc2 : dc3;
      if (rst) begin
        chk($sformatf("u%0d_rst_wr_en", k), we[k], 0);
        chk($sformatf("u%0d_rst_busy", k), bz[k], 0);
        chk($sformatf("u%0d_rst_drop", k), dv, 0);
        act[k] = 0; sent[k] = 0; drop[k] = 0;
      end else begin
        ewe = act[k] && !full;
        chk($sformatf("u%0d_wr_en", k), we[k], ewe);
        chk($sformatf("u%0d_busy", k), bz[k], act[k]);
        chk($sformatf("u%0d_drop", k), dv, drop[k]);
        if (act[k]) chk($sformatf("u%0d_data", k), wd[k], (ms[k] >> (8 * (2 - sent[k]))) & 24'hFF);
        if (we[k] && lc[k] < 16) begin
          lg[k][lc[k]] = wd[k];
          lcy[k][lc[k]] = cyc;
          lc[k]++;
        end
        lst = ewe && sent[k] == rf[k] - 1;
        acc = sv && en && (!act[k] || lst);
        drp = sv && en && act[k] && !lst;
        if (ewe) begin
          sent[k]++;
          if (sent[k] == rf[k]) act[k] = 0;
        end
        if (acc) begin ms[k] = sd; sent[k] = 0; act[k] = 1; end
        if (drp && drop[k] < dmax[k]) drop[k]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 4; k++) lc[k] = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    clr();
  endtask

  task automatic pulse(input logic [23:0] d);
    sv = 1;
    sd = d;
    tick();
    sv = 0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin act[k] = 0; sent[k] = 0; drop[k] = 0; lc[k] = 0; ms[k] = '0; end
    tick();
    do_reset();
    // single sample, all variants
    pulse(24'hA1B2C3);
    @(negedge clk);
    chk("t1_latency_wr_en", we[0], 1);
    chk("t1_first_byte", wd[0], 8'hA1);
    repeat (6) tick();
    chk("t1_count", lc[0], 2);
    chk("t1_b0", lg[0][0], 8'hA1);
    chk("t1_b1", lg[0][1], 8'hB2);
    chk("t1_consecutive", lcy[0][1] - lcy[0][0], 1);
    chk("t1_rf3_count", lc[2], 3);
    chk("t1_rf3_b2", lg[2][2], 8'hC3);
    chk("t1_rf1_count", lc[3], 1);
    chk("t1_rf1_b0", lg[3][0], 8'hA1);
    // backpressure
    do_reset();
    pulse(24'h123456);
    tick();
    full = 1;
    repeat (5) begin
      @(negedge clk);
      chk("t2_stall_wr_en", we[0], 0);
      chk("t2_stall_data", wd[0], 8'h34);
      tick();
    end
    full = 0;
    repeat (6) tick();
    chk("t2_count", lc[0], 2);
    chk("t2_b0", lg[0][0], 8'h12);
    chk("t2_b1", lg[0][1], 8'h34);
    chk("t2_gap", lcy[0][1] - lcy[0][0], 6);
    chk("t2_rf3_b2", lg[2][2], 8'h56);
    // back-to-back chaining
    do_reset();
    pulse(24'h111111);
    tick();
    pulse(24'h222222);
    repeat (6) tick();
    chk("t3_count", lc[0], 4);
    chk("t3_b1", lg[0][1], 8'h11);
    chk("t3_b2", lg[0][2], 8'h22);
    chk("t3_span", lcy[0][3] - lcy[0][0], 3);
    chk("t3_drop", dc0, 0);
    chk("t3_rf3_drop", dc2, 1);
    // overrun and saturation
    do_reset();
    sv = 1; sd = 24'h0A0B0C; tick();
    sd = 24'h0D0E0F; tick();
    sv = 0;
    repeat (5) tick();
    chk("t4_count", lc[0], 2);
    chk("t4_b0", lg[0][0], 8'h0A);
    chk("t4_b1", lg[0][1], 8'h0B);
    chk("t4_drop", dc0, 1);
    for (int i = 0; i < 5; i++) begin
      sv = 1; sd = 24'h300000 + 24'(i); tick();
      tick();
      sv = 0;
      repeat (3) tick();
    end
    chk("t4_drop6", dc0, 6);
    chk("t4_drop_sat", dc1, 2'd3);
    // enable low
    do_reset();
    en = 0;
    repeat (3) begin pulse(24'hDEAD00); tick(); end
    repeat (3) tick();
    chk("t5_no_writes", lc[0], 0);
    chk("t5_no_drop", dc0, 0);
    en = 1;
    pulse(24'h5A6B7C);
    en = 0;
    pulse(24'h010203);
    repeat (5) tick();
    en = 1;
    chk("t5_count", lc[0], 2);
    chk("t5_b1", lg[0][1], 8'h6B);
    chk("t5_drop", dc0, 0);
    // asynchronous reset mid-drain
    do_reset();
    sv = 1; sd = 24'h778899; tick();
    sd = 24'h000000; tick();
    sv = 0;
    #1 rst = 1;
    #1;
    chk("t6_async_wr_en", we[0], 0);
    chk("t6_async_busy", bz[0], 0);
    chk("t6_async_drop", dc0, 0);
    @(posedge clk);
    #2 rst = 0;
    clr();
    pulse(24'hCAFE01);
    repeat (4) tick();
    chk("t6_count", lc[0], 2);
    chk("t6_b0", lg[0][0], 8'hCA);
    chk("t6_b1", lg[0][1], 8'hFE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
